systolic_tile: RTL and testbench



---
 rtl/systolic_pkg.sv | 21 ++
 rtl/pe_mac.sv | 41 ++++
 rtl/systolic_tile.sv | 230 +++++++++++++++++++++++
 tb/tb_systolic_tile.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the output-stationary GEMM tile.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        CAPTURE,
        DRAIN
    } tile_state_t;

    // Cycles needed for the last beat to cross the skewed array diagonal.
    function automatic int flush_len(input int n1, input int n2);
        return n1 + n2 - 1;
    endfunction

    function automatic int prod_w(input int d_w);
        return 2 * d_w;
    endfunction

endpackage

// File: rtl/pe_mac.sv
// One processing element: signed multiply-accumulate with registered
// operand pass-through to the right (a) and downward (b) neighbours.
module pe_mac
    import systolic_pkg::*;
#(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic signed [D_W-1:0]     a_in,
    input  logic signed [D_W-1:0]     b_in,
    output logic signed [D_W-1:0]     a_out,
    output logic signed [D_W-1:0]     b_out,
    output logic signed [D_W_ACC-1:0] acc
);

    localparam int P_W = prod_w(D_W);

    logic signed [P_W-1:0] prod;

    // Signed size casts sign-extend, so the product is full precision.
    assign prod = P_W'(a_in) * P_W'(b_in);

    // NOTE: sequential state uses non-blocking assignments so every PE
    // samples its neighbour's value from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + D_W_ACC'(prod);
        end
    end

endmodule

// File: rtl/systolic_tile.sv
// Output-stationary N1xN2 GEMM tile with internal operand skew, job FSM,
// valid/ready operand intake and column-serial result drain (N2 >= 2).
module systolic_tile
    import systolic_pkg::*;
#(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 32,
    parameter int N1      = 8,
    parameter int N2      = 4,
    parameter int K_W     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [K_W-1:0]                  k_len,
    output logic                            busy,
    output logic                            done,
    input  logic [N1-1:0][D_W-1:0]          a_data,
    input  logic [N2-1:0][D_W-1:0]          b_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [N1-1:0][D_W_ACC-1:0]      d_data,
    output logic [$clog2(N2)-1:0]           d_col,
    output logic                            d_valid,
    output logic                            d_last,
    input  logic                            d_ready
);

    localparam int C_W   = $clog2(N2);
    localparam int F_LEN = flush_len(N1, N2);
    localparam int F_W   = $clog2(F_LEN + 1);
    localparam logic [F_W-1:0] F_LAST   = F_W'(F_LEN - 1);
    localparam logic [C_W-1:0] LAST_COL = C_W'(N2 - 1);

    tile_state_t          state;
    logic [K_W-1:0]       k_q;
    logic [K_W-1:0]       beat_cnt;
    logic [F_W-1:0]       flush_cnt;
    logic [C_W-1:0]       nxt_col;
    logic                 adv;
    logic                 clr;

    logic signed [D_W-1:0]     a_in_q [N1];
    logic signed [D_W-1:0]     b_in_q [N2];
    logic signed [D_W-1:0]     a_skew [N1];
    logic signed [D_W-1:0]     b_skew [N2];
    logic signed [D_W-1:0]     a_pe   [N1][N2];
    logic signed [D_W-1:0]     b_pe   [N1][N2];
    logic signed [D_W_ACC-1:0] acc_w  [N1][N2];
    logic [D_W_ACC-1:0]        res_buf [N2][N1];

    // in_ready mirrors the LOAD state, so a beat is accepted exactly when
    // both handshake signals are high; FLUSH advances unconditionally.
    assign adv     = (in_ready && in_valid) || (state == FLUSH);
    assign clr     = (state == IDLE) && start;
    assign nxt_col = d_col + C_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < N1; i++) a_in_q[i] <= '0;
            for (int j = 0; j < N2; j++) b_in_q[j] <= '0;
        end else if (adv) begin
            for (int i = 0; i < N1; i++) a_in_q[i] <= in_ready ? a_data[i] : '0;
            for (int j = 0; j < N2; j++) b_in_q[j] <= in_ready ? b_data[j] : '0;
        end
    end

    for (genvar i = 0; i < N1; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign a_skew[i] = a_in_q[i];
        end else begin : g_dly
            logic signed [D_W-1:0] sr [i];
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int s = 0; s < i; s++) sr[s] <= '0;
                end else if (adv) begin
                    sr[0] <= a_in_q[i];
                    for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
                end
            end
            assign a_skew[i] = sr[i-1];
        end
    end

    for (genvar j = 0; j < N2; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign b_skew[j] = b_in_q[j];
        end else begin : g_dly
            logic signed [D_W-1:0] sr [j];
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int s = 0; s < j; s++) sr[s] <= '0;
                end else if (adv) begin
                    sr[0] <= b_in_q[j];
                    for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
                end
            end
            assign b_skew[j] = sr[j-1];
        end
    end

    for (genvar i = 0; i < N1; i++) begin : g_row
        for (genvar j = 0; j < N2; j++) begin : g_col
            logic signed [D_W-1:0] a_src;
            logic signed [D_W-1:0] b_src;

            if (j == 0) begin : g_a_edge
                assign a_src = a_skew[i];
            end else begin : g_a_hop
                assign a_src = a_pe[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_src = b_skew[j];
            end else begin : g_b_hop
                assign b_src = b_pe[i-1][j];
            end

            // Operands leaving the right/bottom border have no consumer.
            if (j == N2 - 1) begin : g_a_end
                logic unused_a;
                assign unused_a = ^a_pe[i][j];
            end
            if (i == N1 - 1) begin : g_b_end
                logic unused_b;
                assign unused_b = ^b_pe[i][j];
            end

            pe_mac #(
                .D_W     (D_W),
                .D_W_ACC (D_W_ACC)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (adv),
                .clr   (clr),
                .a_in  (a_src),
                .b_in  (b_src),
                .a_out (a_pe[i][j]),
                .b_out (b_pe[i][j]),
                .acc   (acc_w[i][j])
            );
        end
    end

    // NOTE: the result buffer is storage, not control state; it is always
    // written in CAPTURE before being read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            for (int i = 0; i < N1; i++)
                for (int j = 0; j < N2; j++)
                    res_buf[j][i] <= acc_w[i][j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_q       <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            d_data    <= '0;
            d_col     <= '0;
            d_valid   <= 1'b0;
            d_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_q       <= k_len;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                        busy      <= 1'b1;
                        if (k_len == '0) begin
                            state <= FLUSH;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt + K_W'(1);
                        if (beat_cnt == k_q - K_W'(1)) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + F_W'(1);
                    if (flush_cnt == F_LAST) state <= CAPTURE;
                end
                CAPTURE: begin
                    // Column 0 is presented straight from the array while
                    // the buffer takes its copy on the same edge.
                    state   <= DRAIN;
                    d_valid <= 1'b1;
                    d_col   <= '0;
                    d_last  <= (N2 == 1);
                    for (int i = 0; i < N1; i++) d_data[i] <= acc_w[i][0];
                end
                DRAIN: begin
                    if (d_ready) begin
                        if (d_last) begin
                            state   <= IDLE;
                            d_valid <= 1'b0;
                            d_last  <= 1'b0;
                            d_col   <= '0;
                            d_data  <= '0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            d_col  <= nxt_col;
                            d_last <= (nxt_col == LAST_COL);
                            for (int i = 0; i < N1; i++) d_data[i] <= res_buf[nxt_col][i];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_tile.sv
// Self-checking bench for systolic_tile: directed jobs with random data,
// checked against a plain matrix-product reference model.
module tb_systolic_tile;

    localparam int N1  = 4;
    localparam int N2  = 4;
    localparam int D_W = 8;
    localparam int K_W = 16;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      start = 1'b0;
    logic [K_W-1:0]            k_len = '0;
    logic [N1-1:0][D_W-1:0]    a_data = '0;
    logic [N2-1:0][D_W-1:0]    b_data = '0;
    logic                      in_valid = 1'b0;
    logic                      d_ready = 1'b0;

    logic                      busy, done, in_ready, d_valid, d_last;
    logic [1:0]                d_col;
    logic [N1-1:0][31:0]       d_data;

    logic                      busy16, done16, in_ready16, d_valid16, d_last16;
    logic [1:0]                d_col16;
    logic [N1-1:0][15:0]       d_data16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic signed [7:0] sa [16][N1];
    logic signed [7:0] sb [16][N2];
    logic [31:0]       exp32 [N1][N2];
    logic [15:0]       exp16 [N1][N2];

    systolic_tile #(.D_W(8), .D_W_ACC(32), .N1(N1), .N2(N2), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done),
        .a_data(a_data), .b_data(b_data), .in_valid(in_valid), .in_ready(in_ready),
        .d_data(d_data), .d_col(d_col), .d_valid(d_valid), .d_last(d_last), .d_ready(d_ready)
    );

    systolic_tile #(.D_W(8), .D_W_ACC(16), .N1(N1), .N2(N2), .K_W(K_W)) dut16 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy16), .done(done16),
        .a_data(a_data), .b_data(b_data), .in_valid(in_valid), .in_ready(in_ready16),
        .d_data(d_data16), .d_col(d_col16), .d_valid(d_valid16), .d_last(d_last16), .d_ready(d_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // C[i][j] = sum over k of A[k][i] * B[k][j], wrapped to the result width.
    function automatic void build_model(input int k);
        for (int i = 0; i < N1; i++)
            for (int j = 0; j < N2; j++) begin
                int s = 0;
                for (int kk = 0; kk < k; kk++) s += int'(sa[kk][i]) * int'(sb[kk][j]);
                exp32[i][j] = 32'(s);
                exp16[i][j] = 16'(s);
            end
    endfunction

    task automatic fill_identity();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N1; i++) sa[k][i] = (i == k) ? 8'sd1 : 8'sd0;
            sb[k][0] = 8'(k + 1);
            sb[k][1] = 8'(2 * k);
            sb[k][2] = 8'(-k);
            sb[k][3] = 8'sd7;
        end
    endtask

    task automatic fill_const(input int av, input int bv, input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N1; i++) sa[kk][i] = 8'(av);
            for (int j = 0; j < N2; j++) sb[kk][j] = 8'(bv);
        end
    endtask

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N1; i++) sa[kk][i] = 8'($urandom);
            for (int j = 0; j < N2; j++) sb[kk][j] = 8'($urandom);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_d_valid"}, d_valid, 0);
        check({tag, "_d_last"}, d_last, 0);
        check({tag, "_d_col"}, d_col, 0);
        for (int i = 0; i < N1; i++) check({tag, "_d_data"}, d_data[i], 0);
        check({tag, "_busy16"}, busy16, 0);
        check({tag, "_d_valid16"}, d_valid16, 0);
    endtask

    // Runs one job: pv/pr are in_valid/d_ready percentages. With chk_lat the
    // exact first-d_valid and done cycles are checked (no-stall runs only).
    task automatic run_job(input int k, input int pv, input int pr, input bit chk_lat,
                           input bit chk16, input bit start_in_drain);
        int idx, col, guard, s;
        bit v, r, stalled, seen, sent;
        logic [N1-1:0][31:0] prev_data;
        logic [1:0] prev_col;
        logic prev_last;

        build_model(k);
        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(k);
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        k_len = K_W'($urandom);
        check("busy_rise", busy, 1);
        check("in_ready_rise", in_ready, (k != 0));
        if (chk16) check("in_ready16_rise", in_ready16, (k != 0));

        idx = 0;
        guard = 0;
        while (idx < k && guard < 2000) begin
            v = ($urandom_range(99) < pv);
            in_valid = v;
            if (v) begin
                for (int i = 0; i < N1; i++) a_data[i] = sa[idx][i];
                for (int j = 0; j < N2; j++) b_data[j] = sb[idx][j];
            end else begin
                a_data = $urandom;
                b_data = $urandom;
            end
            check("in_ready_load", in_ready, 1);
            if (v && in_ready) idx++;
            @(negedge clk);
            guard++;
        end
        check("load_beats", idx, k);

        // A beat offered right after the last one must be refused.
        check("in_ready_drop", in_ready, 0);
        in_valid = 1'b1;
        a_data = $urandom;
        b_data = $urandom;
        @(negedge clk);
        in_valid = 1'b0;

        col = 0;
        guard = 0;
        stalled = 1'b0;
        seen = 1'b0;
        sent = 1'b0;
        while (col < N2 && guard < 500) begin
            if (d_valid) begin
                if (chk_lat && !seen) check("first_d_valid_cycle", cyc - s, k + 9);
                seen = 1'b1;
                if (stalled) begin
                    check("stall_col", d_col, prev_col);
                    check("stall_last", d_last, prev_last);
                    check("stall_data", d_data, prev_data);
                end
                check("d_col", d_col, col);
                check("d_last", d_last, (col == N2 - 1));
                for (int i = 0; i < N1; i++) check("d_data", d_data[i], exp32[i][col]);
                if (chk16) begin
                    check("d_valid16", d_valid16, 1);
                    check("d_col16", d_col16, col);
                    check("d_last16", d_last16, (col == N2 - 1));
                    for (int i = 0; i < N1; i++) check("d_data16", d_data16[i], exp16[i][col]);
                end
                if (start_in_drain && !sent) begin
                    start = 1'b1;
                    k_len = K_W'(3);
                    sent = 1'b1;
                end
                r = ($urandom_range(99) < pr);
                d_ready = r;
                prev_col = d_col;
                prev_last = d_last;
                prev_data = d_data;
                if (r) begin
                    col++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end else begin
                if (col > 0) check("d_valid_hold", d_valid, 1);
                d_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
            start = 1'b0;
            guard++;
        end
        check("drain_beats", col, N2);
        d_ready = 1'b0;

        check("done_pulse", done, 1);
        check("busy_fall", busy, 0);
        check("d_valid_after", d_valid, 0);
        check("d_last_after", d_last, 0);
        if (chk_lat) check("done_cycle", cyc - s, k + 13);
        if (chk16) check("done16_pulse", done16, 1);
        @(negedge clk);
        check("done_single", done, 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        fill_identity();
        run_job(4, 100, 100, 1'b1, 1'b0, 1'b0);

        fill_const(-128, -128, 4);
        run_job(4, 100, 100, 1'b1, 1'b0, 1'b0);
        fill_const(-128, 127, 4);
        run_job(4, 100, 100, 1'b1, 1'b0, 1'b0);

        fill_random(9);
        run_job(9, 50, 50, 1'b0, 1'b0, 1'b0);
        fill_random(9);
        run_job(9, 50, 50, 1'b0, 1'b0, 1'b0);

        run_job(0, 100, 100, 1'b1, 1'b0, 1'b0);

        fill_const(127, 127, 3);
        run_job(3, 100, 100, 1'b1, 1'b1, 1'b0);

        // Reset while beat 2 of a five-beat job is on the inputs.
        fill_random(5);
        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(5);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b1;
            for (int i = 0; i < N1; i++) a_data[i] = sa[b][i];
            for (int j = 0; j < N2; j++) b_data[j] = sb[b][j];
        end
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        in_valid = 1'b0;

        fill_random(6);
        run_job(6, 100, 100, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
